// File: rtl/muldiv_sequencer.sv
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Iterative multiply/divide engine for the pipelined MIPS core.
//            Runs a one-bit-per-cycle shift-add multiply or restoring divide,
//            owns the HI/LO register pair and raises the pipeline stall while
//            the shared arithmetic resource is busy.
// Config   : `define MULDIV_SIGNED_EN for two's-complement mult/div (adds a
//            sign-fix cycle); default build is unsigned multu/divu.
// Ports    : clk, reset (sync, active-high)
//            multE, divE         - start requests from Execute (mult wins)
//            srcaE, srcbE        - multiplicand/dividend, multiplier/divisor
//            readhiloD           - Decode holds mfhi/mflo
//            hi, lo              - HI/LO result registers
//            busy, stall         - operation in progress / pipeline freeze
//            done, divzero       - one-cycle result pulse / divisor-was-zero
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             multE,
    input  logic             divE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             readhiloD,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             divzero
);

    localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
`ifdef MULDIV_SIGNED_EN
    localparam logic [1:0] c_FIX  = 2'd2;
`endif

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_count;
    logic               r_isDiv;
    logic               r_divByZero;
    logic [WIDTH-1:0]   r_operand;   // multiplicand or divisor (magnitude)
    logic [WIDTH-1:0]   r_dividend;  // raw dividend, returned as HI on /0
    logic [2*WIDTH-1:0] r_acc;       // product or remainder:quotient pair
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dzPulse;
`ifdef MULDIV_SIGNED_EN
    logic               r_negRes;
    logic               r_negRem;
`endif

    // Operand values latched at start: magnitudes in the signed build.
    logic [WIDTH-1:0] w_opA;
    logic [WIDTH-1:0] w_opB;
`ifdef MULDIV_SIGNED_EN
    assign w_opA = srcaE[WIDTH-1] ? -srcaE : srcaE;
    assign w_opB = srcbE[WIDTH-1] ? -srcbE : srcbE;
`else
    assign w_opA = srcaE;
    assign w_opB = srcbE;
`endif

    // Multiply step: the upper-half add carries one bit out, which becomes
    // the MSB after the right shift.
    logic [WIDTH:0]     w_mulUpper;
    logic [2*WIDTH-1:0] w_mulNext;
    assign w_mulUpper = r_acc[0] ? ({1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_operand})
                                 : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    assign w_mulNext  = {w_mulUpper, r_acc[WIDTH-1:1]};

    // Divide step: the shifted remainder needs WIDTH+1 bits because it can
    // reach 2*divisor-1. When the trial subtract succeeds the difference is
    // below the divisor, so its low WIDTH bits are exact.
    logic [WIDTH:0]     w_remShift;
    logic               w_fits;
    logic [WIDTH-1:0]   w_remDiff;
    logic [WIDTH-1:0]   w_remNext;
    logic [2*WIDTH-1:0] w_divNext;
    assign w_remShift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_fits     = (w_remShift >= {1'b0, r_operand});
    assign w_remDiff  = w_remShift[WIDTH-1:0] - r_operand;
    assign w_remNext  = w_fits ? w_remDiff : w_remShift[WIDTH-1:0];
    assign w_divNext  = {w_remNext, r_acc[WIDTH-2:0], w_fits};

    logic [2*WIDTH-1:0] w_stepNext;
    assign w_stepNext = r_isDiv ? w_divNext : w_mulNext;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_count     <= '0;
            r_isDiv     <= 1'b0;
            r_divByZero <= 1'b0;
            r_operand   <= '0;
            r_dividend  <= '0;
            r_acc       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_done      <= 1'b0;
            r_dzPulse   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            r_negRes    <= 1'b0;
            r_negRem    <= 1'b0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_dzPulse <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (multE || divE) begin
                        r_count    <= '0;
                        r_dividend <= srcaE;
                        r_state    <= c_RUN;
`ifdef MULDIV_SIGNED_EN
                        r_negRes   <= srcaE[WIDTH-1] ^ srcbE[WIDTH-1];
                        r_negRem   <= srcaE[WIDTH-1];
`endif
                        if (multE) begin
                            r_isDiv     <= 1'b0;
                            r_divByZero <= 1'b0;
                            r_operand   <= w_opA;
                            r_acc       <= {{WIDTH{1'b0}}, w_opB};
                        end else begin
                            r_isDiv     <= 1'b1;
                            r_divByZero <= (srcbE == '0);
                            r_operand   <= w_opB;
                            r_acc       <= {{WIDTH{1'b0}}, w_opA};
                        end
                    end
                end
                c_RUN: begin
                    r_acc   <= w_stepNext;
                    r_count <= r_count + 1'b1;
                    if (r_count == c_LAST) begin
                        r_count <= '0;
`ifdef MULDIV_SIGNED_EN
                        r_state <= c_FIX;
`else
                        r_hi      <= r_divByZero ? r_dividend : w_stepNext[2*WIDTH-1:WIDTH];
                        r_lo      <= r_divByZero ? {WIDTH{1'b1}} : w_stepNext[WIDTH-1:0];
                        r_done    <= 1'b1;
                        r_dzPulse <= r_divByZero;
                        r_state   <= c_IDLE;
`endif
                    end
                end
`ifdef MULDIV_SIGNED_EN
                c_FIX: begin
                    if (r_divByZero) begin
                        r_hi <= r_dividend;
                        r_lo <= {WIDTH{1'b1}};
                    end else if (!r_isDiv) begin
                        {r_hi, r_lo} <= r_negRes ? -r_acc : r_acc;
                    end else begin
                        r_lo <= r_negRes ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
                        r_hi <= r_negRem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
                    end
                    r_done    <= 1'b1;
                    r_dzPulse <= r_divByZero;
                    r_state   <= c_IDLE;
                end
`endif
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign hi      = r_hi;
    assign lo      = r_lo;
    assign busy    = (r_state != c_IDLE);
    assign stall   = busy & (multE | divE | readhiloD);
    assign done    = r_done;
    assign divzero = r_dzPulse;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// Module   : tb_muldiv_sequencer
// Purpose  : Self-checking bench for muldiv_sequencer. Table of operations run
//            back-to-back with a result scoreboard, plus hand-written
//            sequences for stall, ignored requests, mid-operation reset and
//            simultaneous start requests.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;

    localparam int WIDTH = 32;
`ifdef MULDIV_SIGNED_EN
    localparam int c_LAT = WIDTH + 1;
`else
    localparam int c_LAT = WIDTH;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        bit          dz;
    } exp_t;

    typedef struct {
        bit          isDiv;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        multE;
    logic        divE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        readhiloD;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;
    logic        divzero;

    int          checks;
    int          failures;
    exp_t        sb[$];
    vec_t        vecs[$];
    logic [31:0] curHi;
    logic [31:0] curLo;

    muldiv_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .multE     (multE),
        .divE      (divE),
        .srcaE     (srcaE),
        .srcbE     (srcbE),
        .readhiloD (readhiloD),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .divzero   (divzero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference arithmetic, independent of the shift/subtract algorithm.
    function automatic exp_t model(input bit isDiv, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
`ifdef MULDIV_SIGNED_EN
        longint sa;
        longint sb2;
        longint sp;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        sp  = sa * sb2;
`else
        logic [63:0] up;
        up = {32'd0, a} * {32'd0, b};
`endif
        e.hi = '0;
        e.lo = '0;
        e.dz = 1'b0;
        if (isDiv && b == 32'd0) begin
            e.hi = a;
            e.lo = 32'hFFFF_FFFF;
            e.dz = 1'b1;
        end
`ifdef MULDIV_SIGNED_EN
        else if (!isDiv) {e.hi, e.lo} = sp;
        else begin
            e.lo = 32'(sa / sb2);
            e.hi = 32'(sa % sb2);
        end
`else
        else if (!isDiv) {e.hi, e.lo} = up;
        else begin
            e.lo = a / b;
            e.hi = a % b;
        end
`endif
        return e;
    endfunction

    function automatic vec_t mkVec(input bit isDiv, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] eHi, input logic [31:0] eLo, input bit eDz);
        vec_t v;
        v.isDiv = isDiv;
        v.a     = a;
        v.b     = b;
        v.e.hi  = eHi;
        v.e.lo  = eLo;
        v.e.dz  = eDz;
        return v;
    endfunction

    function automatic vec_t mkRand(input bit isDiv);
        vec_t v;
        v.isDiv = isDiv;
        v.a     = $urandom;
        v.b     = $urandom;
        v.e     = model(isDiv, v.a, v.b);
        return v;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge of busy cycle 1.
    task automatic startOp(input bit isDiv, input bit both, input logic [31:0] a,
                           input logic [31:0] b, input bit push, input exp_t e);
        multE = !isDiv || both;
        divE  = isDiv || both;
        srcaE = a;
        srcbE = b;
        if (push) sb.push_back(e);
        @(negedge clk);
        multE = 1'b0;
        divE  = 1'b0;
    endtask

    // Counts busy cycles from the current negedge; returns at the done-cycle negedge.
    task automatic waitDone(input string name, input int already);
        int   n;
        bit   stable;
        exp_t e;
        n      = already;
        stable = 1'b1;
        while (busy === 1'b1 && n < c_LAT + 4) begin
            n++;
            if (hi !== curHi || lo !== curLo || done !== 1'b0) stable = 1'b0;
            @(negedge clk);
        end
        check({name, "_latency"}, 64'(n), 64'(c_LAT));
        check({name, "_hilo_stable"}, 64'(stable), 64'd1);
        check({name, "_done"}, 64'(done), 64'd1);
        check({name, "_busy_in_done"}, 64'(busy), 64'd0);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_scoreboard actual=empty expected=entry", name);
        end else begin
            e = sb.pop_front();
            check({name, "_hi"}, 64'(hi), 64'(e.hi));
            check({name, "_lo"}, 64'(lo), 64'(e.lo));
            check({name, "_divzero"}, 64'(divzero), 64'(e.dz));
            curHi = e.hi;
            curLo = e.lo;
        end
    endtask

    initial begin
        bit   sawDone;
        bit   sawBusy;
        exp_t eMul;

        checks    = 0;
        failures  = 0;
        curHi     = '0;
        curLo     = '0;
        reset     = 1'b1;
        multE     = 1'b0;
        divE      = 1'b0;
        srcaE     = '0;
        srcbE     = '0;
        readhiloD = 1'b0;

`ifdef MULDIV_SIGNED_EN
        vecs.push_back(mkVec(0, 32'd6,          32'd7,          32'h0,          32'd42,         0));
        vecs.push_back(mkVec(0, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF,  32'hFFFF_FFF1,  0));
        vecs.push_back(mkVec(1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  0));
        vecs.push_back(mkVec(1, 32'd100,        32'd7,          32'd2,          32'd14,         0));
        vecs.push_back(mkVec(1, 32'd100,        32'd0,          32'd100,        32'hFFFF_FFFF,  1));
        vecs.push_back(mkVec(1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          32'h8000_0000,  0));
        vecs.push_back(mkVec(0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0,          32'h1,          0));
        vecs.push_back(mkVec(1, 32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD,  0));
        vecs.push_back(mkVec(1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  32'hFFFF_FFFF,  1));
`else
        vecs.push_back(mkVec(0, 32'd6,          32'd7,          32'h0,          32'd42,         0));
        vecs.push_back(mkVec(0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h1,          0));
        vecs.push_back(mkVec(1, 32'd100,        32'd7,          32'd2,          32'd14,         0));
        vecs.push_back(mkVec(1, 32'd100,        32'd0,          32'd100,        32'hFFFF_FFFF,  1));
        vecs.push_back(mkVec(0, 32'd0,          32'd12345,      32'h0,          32'h0,          0));
        vecs.push_back(mkVec(1, 32'd7,          32'd100,        32'd7,          32'd0,          0));
        vecs.push_back(mkVec(1, 32'hFFFF_FFFF,  32'd1,          32'h0,          32'hFFFF_FFFF,  0));
        vecs.push_back(mkVec(1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'h0,          0));
        vecs.push_back(mkVec(0, 32'h8000_0000,  32'd2,          32'h1,          32'h0,          0));
        vecs.push_back(mkVec(1, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  32'h1,          0));
`endif
        for (int i = 0; i < 3; i++) vecs.push_back(mkRand(0));
        for (int i = 0; i < 3; i++) vecs.push_back(mkRand(1));

        // Reset values.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_divzero", 64'(divzero), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);

        // Table: each op starts in the previous op's done cycle (no gap).
        for (int i = 0; i < vecs.size(); i++) begin
            startOp(vecs[i].isDiv, 1'b0, vecs[i].a, vecs[i].b, 1'b1, vecs[i].e);
            waitDone($sformatf("vec%0d", i), 0);
        end

        // Requests and mfhi/mflo while busy: stall, no acceptance, no queueing.
        eMul = model(1'b0, 32'd1234, 32'd5678);
        startOp(1'b0, 1'b0, 32'd1234, 32'd5678, 1'b1, eMul);
        divE      = 1'b1;
        srcaE     = 32'd99;
        srcbE     = 32'd0;
        readhiloD = 1'b1;
        #1 check("stall_div_readhilo", 64'(stall), 64'd1);
        @(negedge clk);
        divE = 1'b0;
        #1 check("stall_readhilo", 64'(stall), 64'd1);
        @(negedge clk);
        readhiloD = 1'b0;
        #1 check("stall_idle_inputs", 64'(stall), 64'd0);
        waitDone("ignored_req", 2);
        readhiloD = 1'b1;
        #1 check("stall_in_done_cycle", 64'(stall), 64'd0);
        check("readhilo_done_lo", 64'(lo), 64'(eMul.lo));
        readhiloD = 1'b0;
        @(negedge clk);
        check("no_queued_op_busy", 64'(busy), 64'd0);
        check("no_queued_op_done", 64'(done), 64'd0);
        check("no_queued_op_lo", 64'(lo), 64'(eMul.lo));

        // Reset at busy cycle 10 aborts the multiply.
        startOp(1'b0, 1'b0, 32'd6, 32'd7, 1'b0, eMul);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        curHi   = '0;
        curLo   = '0;
        sawDone = 1'b0;
        sawBusy = 1'b0;
        for (int i = 0; i < c_LAT + 8; i++) begin
            if (done === 1'b1) sawDone = 1'b1;
            if (busy === 1'b1) sawBusy = 1'b1;
            @(negedge clk);
        end
        check("abort_no_done", 64'(sawDone), 64'd0);
        check("abort_no_busy", 64'(sawBusy), 64'd0);

        // Simultaneous multE and divE: multiply wins.
        eMul.hi = 32'd0;
        eMul.lo = 32'd6;
        eMul.dz = 1'b0;
        startOp(1'b0, 1'b1, 32'd2, 32'd3, 1'b1, eMul);
        waitDone("both_req", 0);
        @(negedge clk);
        check("done_single_pulse", 64'(done), 64'd0);
        check("divzero_single_pulse", 64'(divzero), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
